// File: rtl/fetcher_pkg.sv
// Shared encodings for the core phase and the instruction fetcher FSM.
// Imported by fetcher and fetcher_line_buffer.
package fetcher_pkg;

   typedef enum logic [2:0] {
      CORE_IDLE    = 3'b000,
      CORE_FETCH   = 3'b001,
      CORE_DECODE  = 3'b010,
      CORE_REQUEST = 3'b011,
      CORE_WAIT    = 3'b100,
      CORE_EXECUTE = 3'b101,
      CORE_UPDATE  = 3'b110,
      CORE_DONE    = 3'b111
   } core_state_e;

   typedef enum logic [2:0] {
      FS_IDLE     = 3'b000,
      FS_FETCHING = 3'b001,
      FS_FETCHED  = 3'b010
   } fetch_state_e;

endpackage

// File: rtl/fetcher_line_buffer.sv
// Single-entry instruction cache line (tag + word + valid).
// Flush wins over a same-edge write so a flushed line never looks valid.
module fetcher_line_buffer
   import fetcher_pkg::*;
#(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_tag,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic [ADDR_BITS-1:0] lookup_tag,
   output logic                 hit,
   output logic [DATA_BITS-1:0] rd_data
);

   logic                 valid;
   logic [ADDR_BITS-1:0] tag;
   logic [DATA_BITS-1:0] data;

   // Line update: refill on capture, invalidate on flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         tag   <= '0;
         data  <= '0;
      end else begin
         if (wr_en) begin
            valid <= 1'b1;
            tag   <= wr_tag;
            data  <= wr_data;
         end
         if (flush) begin
            valid <= 1'b0;
         end
      end
   end

   assign hit     = valid && (tag == lookup_tag);
   assign rd_data = data;

endmodule

// File: rtl/fetcher.sv
// Instruction fetcher: one program-memory read per FETCH phase.
// Define FETCHER_CACHE_EN to add a single-entry instruction cache.
module fetcher
   import fetcher_pkg::*;
#(
   parameter int PROGRAM_MEM_ADDR_BITS = 8,
   parameter int PROGRAM_MEM_DATA_BITS = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [2:0]                       core_state,
   input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
   input  logic                             flush,
   output logic                             mem_read_valid,
   output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
   input  logic                             mem_read_ready,
   input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
   output logic [2:0]                       fetcher_state,
   output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

   fetch_state_e                     state;
   logic                             capture;
   logic                             hit;
   logic [PROGRAM_MEM_DATA_BITS-1:0] cache_word;

   assign capture = (state == FS_FETCHING) && mem_read_ready;

`ifdef FETCHER_CACHE_EN
   fetcher_line_buffer #(
      .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
      .DATA_BITS (PROGRAM_MEM_DATA_BITS)
   ) u_line (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .wr_en      (capture),
      .wr_tag     (mem_read_address),
      .wr_data    (mem_read_data),
      .lookup_tag (current_pc),
      .hit        (hit),
      .rd_data    (cache_word)
   );
`else
   logic unused_flush;
   assign unused_flush = flush;
   assign hit          = 1'b0;
   assign cache_word   = '0;
`endif

   // Fetch FSM with registered request and instruction outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= FS_IDLE;
         mem_read_valid   <= 1'b0;
         mem_read_address <= '0;
         instruction      <= '0;
      end else begin
         case (state)
            FS_IDLE: begin
               if (core_state == CORE_FETCH) begin
                  if (hit) begin
                     instruction <= cache_word;
                     state       <= FS_FETCHED;
                  end else begin
                     mem_read_valid   <= 1'b1;
                     mem_read_address <= current_pc;
                     state            <= FS_FETCHING;
                  end
               end
            end
            FS_FETCHING: begin
               if (capture) begin
                  instruction    <= mem_read_data;
                  mem_read_valid <= 1'b0;
                  state          <= FS_FETCHED;
               end
            end
            FS_FETCHED: begin
               if (core_state == CORE_DECODE) begin
                  state <= FS_IDLE;
               end
            end
            default: begin
               mem_read_valid <= 1'b0;
               state          <= FS_IDLE;
            end
         endcase
      end
   end

   assign fetcher_state = state;

endmodule

// File: tb/tb_fetcher.sv
// Scoreboard bench for fetcher: driver pushes expected requests and
// instructions, a negedge monitor pops and compares them.
module tb_fetcher;
   import fetcher_pkg::*;

   localparam int AW = 8;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    core_state;
   logic [AW-1:0] current_pc;
   logic          flush;
   logic          mem_read_valid;
   logic [AW-1:0] mem_read_address;
   logic          mem_read_ready;
   logic [DW-1:0] mem_read_data;
   logic [2:0]    fetcher_state;
   logic [DW-1:0] instruction;

   fetcher #(
      .PROGRAM_MEM_ADDR_BITS (AW),
      .PROGRAM_MEM_DATA_BITS (DW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .core_state       (core_state),
      .current_pc       (current_pc),
      .flush            (flush),
      .mem_read_valid   (mem_read_valid),
      .mem_read_address (mem_read_address),
      .mem_read_ready   (mem_read_ready),
      .mem_read_data    (mem_read_data),
      .fetcher_state    (fetcher_state),
      .instruction      (instruction)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [AW-1:0] addr_q[$];
   logic [DW-1:0] instr_q[$];
   int            lat_q[$];
   bit            mon_en = 1'b0;

   // reference cache contents and last delivered instruction
   bit            cv = 1'b0;
   logic [AW-1:0] ct = '0;
   logic [DW-1:0] cd = '0;
   logic [DW-1:0] last_instr = '0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: compares requests, valid duration and captured words
   initial begin
      logic          pv;
      logic [2:0]    ps;
      int            vcnt;
      logic [AW-1:0] ea;
      pv = 1'b0; ps = 3'b000; vcnt = 0; ea = '0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            pv = 1'b0; ps = 3'b000; vcnt = 0;
         end else begin
            if (mem_read_valid && !pv) begin
               vcnt = 0;
               if (addr_q.size() == 0) chk("unexpected_req", 1, 0);
               else begin
                  ea = addr_q.pop_front();
                  chk("req_addr", mem_read_address, ea);
               end
            end
            if (mem_read_valid) begin
               vcnt++;
               chk("addr_stable", mem_read_address, ea);
            end
            if (!mem_read_valid && pv) begin
               if (lat_q.size() == 0) chk("unexpected_drop", 1, 0);
               else chk("valid_cycles", vcnt, lat_q.pop_front());
            end
            if (fetcher_state == 3'b010 && ps != 3'b010) begin
               if (instr_q.size() == 0) chk("unexpected_fetched", 1, 0);
               else chk("instr", instruction, instr_q.pop_front());
            end
            pv = mem_read_valid;
            ps = fetcher_state;
         end
      end
   end

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
`ifdef FETCHER_CACHE_EN
      cv = 1'b0;
`endif
   endtask

   task automatic do_fetch(logic [AW-1:0] pc, logic [DW-1:0] data, int lat,
                           bit chg, bit wander, bit early, bit fl_cap,
                           bit stray);
      bit            hit;
      logic [DW-1:0] exp_i;
`ifdef FETCHER_CACHE_EN
      hit = cv && (ct == pc);
`else
      hit = 1'b0;
`endif
      exp_i = hit ? cd : data;
      core_state = CORE_FETCH;
      current_pc = pc;
      if (early) begin
         mem_read_ready = 1'b1;
         mem_read_data  = ~data;
      end
      instr_q.push_back(exp_i);
      if (!hit) begin
         addr_q.push_back(pc);
         lat_q.push_back(lat);
      end
      @(posedge clk); #1;
      mem_read_ready = 1'b0;
      if (!hit) begin
         if (chg) current_pc = pc ^ 8'h0c;
         if (wander) core_state = CORE_REQUEST;
         repeat (lat - 1) begin
            @(posedge clk); #1;
         end
         mem_read_ready = 1'b1;
         mem_read_data  = data;
         flush          = fl_cap;
         @(posedge clk); #1;
         mem_read_ready = 1'b0;
         flush          = 1'b0;
`ifdef FETCHER_CACHE_EN
         if (fl_cap) cv = 1'b0;
         else begin
            cv = 1'b1; ct = pc; cd = data;
         end
`endif
      end
      last_instr = exp_i;
      if (stray) begin
         core_state     = CORE_EXECUTE;
         mem_read_ready = 1'b1;
         mem_read_data  = ~exp_i;
         @(posedge clk); #1;
         mem_read_ready = 1'b0;
         chk("stray_fetched_state", fetcher_state, 3'b010);
         chk("stray_fetched_instr", instruction, exp_i);
      end
      core_state = CORE_DECODE;
      @(posedge clk); #1;
      chk("back_idle", fetcher_state, 3'b000);
      core_state = CORE_IDLE;
      current_pc = AW'($urandom);
   endtask

   task automatic idle_stray();
      mem_read_ready = 1'b1;
      mem_read_data  = DW'($urandom);
      repeat (2) begin
         @(posedge clk); #1;
      end
      mem_read_ready = 1'b0;
      chk("idle_stray_state", fetcher_state, 3'b000);
      chk("idle_stray_valid", mem_read_valid, 1'b0);
      chk("idle_stray_instr", instruction, last_instr);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      core_state     = CORE_IDLE;
      current_pc     = '0;
      flush          = 1'b0;
      mem_read_ready = 1'b0;
      mem_read_data  = '0;
      #1 reset = 1'b0;
      #2;
      chk("rst_state", fetcher_state, 3'b000);
      chk("rst_valid", mem_read_valid, 1'b0);
      chk("rst_addr", mem_read_address, 8'h00);
      chk("rst_instr", instruction, 16'h0000);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      mon_en = 1'b1;

      // pc 0x05, ready after 3 valid cycles, pc moved to 0x09 mid-fetch
      do_fetch(8'h05, 16'h1234, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_stray();

`ifdef FETCHER_CACHE_EN
      do_fetch(8'h05, 16'hffff, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("hit_instr", instruction, 16'h1234);
      pulse_flush();
      do_fetch(8'h05, 16'h4321, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0) pulse_flush();
         do_fetch(AW'($urandom_range(0, 7)), DW'($urandom),
                  int'($urandom_range(1, 4)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 4) == 0);
         if ($urandom_range(0, 5) == 0) idle_stray();
      end

      // async reset in the middle of FETCHING
      mon_en     = 1'b0;
      core_state = CORE_FETCH;
      current_pc = 8'h33;
      @(posedge clk); #1;
      core_state = CORE_IDLE;
      @(posedge clk); #1;
      chk("pre_rst_valid", mem_read_valid, 1'b1);
      #3 reset = 1'b0;
      #1;
      chk("async_rst_valid", mem_read_valid, 1'b0);
      chk("async_rst_state", fetcher_state, 3'b000);
      chk("async_rst_addr", mem_read_address, 8'h00);
      chk("async_rst_instr", instruction, 16'h0000);
      @(posedge clk); #1;
      reset = 1'b1;
      cv = 1'b0;
      last_instr = '0;
      addr_q.delete();
      instr_q.delete();
      lat_q.delete();
      idle_stray();
      mon_en = 1'b1;

      do_fetch(8'h21, 16'h5a5a, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("addr_q_empty", addr_q.size(), 0);
      chk("instr_q_empty", instr_q.size(), 0);
      chk("lat_q_empty", lat_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
